// File: rtl/dram_cache_pkg.sv
// Shared types for the DRAM request path.
// Holds the DRAM command encoding, the issuer FSM state encoding, default
// field widths of a request word and a helper that sizes the request word.
// No ports: this is a package.
package dram_cache_pkg;

   localparam int CMD_W = 3;

   typedef enum logic [CMD_W-1:0] {
      CMD_NOP = 3'd0,
      CMD_ACT = 3'd1,
      CMD_RD  = 3'd2,
      CMD_WR  = 3'd3,
      CMD_PRE = 3'd4
   } cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_PRE,
      ST_ACT,
      ST_CAS,
      ST_WAIT
   } state_e;

   localparam int DEF_BANK_BITS = 2;
   localparam int DEF_ROW_BITS  = 8;
   localparam int DEF_COL_BITS  = 4;

   // Request word layout, MSB first: {is_write, bank, row, col}
   function automatic int req_w(input int bank_bits, input int row_bits, input int col_bits);
      return 1 + bank_bits + row_bits + col_bits;
   endfunction

endpackage

// File: rtl/dram_req_issuer_if.sv
// Bus bundle between the request FIFO / DRAM command port and the issuer.
// FIFO side : fifo_empty, fifo_rdata (show-ahead head) in, fifo_read_en out
// DRAM side : cmd, cmd_bank, cmd_addr out
// Cache side: req_done, req_done_wr, busy out
// modport master = the issuer itself; modport slave = its environment.
interface dram_req_issuer_if
   import dram_cache_pkg::*;
#(
   parameter int BANK_BITS = DEF_BANK_BITS,
   parameter int ROW_BITS  = DEF_ROW_BITS,
   parameter int COL_BITS  = DEF_COL_BITS
) ();
   localparam int REQ_W = req_w(BANK_BITS, ROW_BITS, COL_BITS);

   logic                 fifo_empty;
   logic [REQ_W-1:0]     fifo_rdata;
   logic                 fifo_read_en;
   logic [CMD_W-1:0]     cmd;
   logic [BANK_BITS-1:0] cmd_bank;
   logic [ROW_BITS-1:0]  cmd_addr;
   logic                 req_done;
   logic                 req_done_wr;
   logic                 busy;

   modport master (
      input  fifo_empty, fifo_rdata,
      output fifo_read_en, cmd, cmd_bank, cmd_addr, req_done, req_done_wr, busy
   );

   modport slave (
      output fifo_empty, fifo_rdata,
      input  fifo_read_en, cmd, cmd_bank, cmd_addr, req_done, req_done_wr, busy
   );
endinterface

// File: rtl/dram_bank_table.sv
// Open-row table: one {open, row} entry per bank.
// Ports: clk, reset (async, active high, clears every entry),
//        lk_bank/lk_row -> lk_open/lk_hit (combinational lookup),
//        upd_bank with set_en/set_row (ACT opens a row) and clr_en (PRE closes it).
module dram_bank_table #(
   parameter int BANK_BITS = 2,
   parameter int ROW_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BANK_BITS-1:0] lk_bank,
   input  logic [ROW_BITS-1:0]  lk_row,
   output logic                 lk_open,
   output logic                 lk_hit,
   input  logic [BANK_BITS-1:0] upd_bank,
   input  logic                 set_en,
   input  logic [ROW_BITS-1:0]  set_row,
   input  logic                 clr_en
);
   localparam int NUM_BANKS = 2 ** BANK_BITS;

   logic [NUM_BANKS-1:0] open_q, open_d;
   logic [ROW_BITS-1:0]  row_q [NUM_BANKS];
   logic [ROW_BITS-1:0]  row_d [NUM_BANKS];

   assign lk_open = open_q[lk_bank];
   assign lk_hit  = lk_open && (row_q[lk_bank] == lk_row);

   always_comb begin
      open_d = open_q;
      row_d  = row_q;
      if (clr_en) open_d[upd_bank] = 1'b0;
      if (set_en) begin
         open_d[upd_bank] = 1'b1;
         row_d[upd_bank]  = set_row;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         open_q <= '0;
         for (int b = 0; b < NUM_BANKS; b++) row_q[b] <= '0;
      end else begin
         open_q <= open_d;
         row_q  <= row_d;
      end
   end
endmodule

// File: rtl/dram_req_issuer.sv
// DRAM request issuer: pops one request at a time from a show-ahead FIFO,
// issues PRE/ACT/RD/WR with fixed gaps using an open-page row table, and
// pulses req_done when the access completes.
// Ports: clk, reset (async, active high), bus (dram_req_issuer_if.master).
//
// state  | meaning
// IDLE   | waiting for a request; pops when the FIFO is not empty
// DECODE | row-table lookup picks ACT (closed), CAS (hit) or PRE (conflict)
// PRE    | PRE on the bus, bank closed
// ACT    | ACT with row on the bus, bank opened
// CAS    | RD or WR with column on the bus
// WAIT   | timer running; ret_q says which command started it
module dram_req_issuer
   import dram_cache_pkg::*;
#(
   parameter int BANK_BITS = DEF_BANK_BITS,
   parameter int ROW_BITS  = DEF_ROW_BITS,
   parameter int COL_BITS  = DEF_COL_BITS,
   parameter int T_RP      = 3,
   parameter int T_RCD     = 3,
   parameter int T_CL      = 4,
   parameter int T_WR      = 4
) (
   input logic              clk,
   input logic              reset,
   dram_req_issuer_if.master bus
);
   localparam int REQ_W    = req_w(BANK_BITS, ROW_BITS, COL_BITS);
   localparam int OFF_ROW  = COL_BITS;
   localparam int OFF_BANK = COL_BITS + ROW_BITS;

   state_e               state_q, state_d, ret_q, ret_d;
   logic [3:0]           timer_q, timer_d;
   logic [REQ_W-1:0]     req_q, req_d;

   logic                 req_wr;
   logic [BANK_BITS-1:0] req_bank;
   logic [ROW_BITS-1:0]  req_row;
   logic [COL_BITS-1:0]  req_col;

   logic                 lk_open, lk_hit, tbl_set, tbl_clr;
   logic                 pop, done;
   cmd_e                 cmd_s;
   logic [BANK_BITS-1:0] cmd_bank_s;
   logic [ROW_BITS-1:0]  cmd_addr_s;

   assign req_wr   = req_q[REQ_W-1];
   assign req_bank = req_q[OFF_BANK +: BANK_BITS];
   assign req_row  = req_q[OFF_ROW +: ROW_BITS];
   assign req_col  = req_q[0 +: COL_BITS];

   dram_bank_table #(.BANK_BITS(BANK_BITS), .ROW_BITS(ROW_BITS)) u_bank_table (
      .clk      (clk),
      .reset    (reset),
      .lk_bank  (req_bank),
      .lk_row   (req_row),
      .lk_open  (lk_open),
      .lk_hit   (lk_hit),
      .upd_bank (req_bank),
      .set_en   (tbl_set),
      .set_row  (req_row),
      .clr_en   (tbl_clr)
   );

   always_comb begin
      state_d    = state_q;
      ret_d      = ret_q;
      timer_d    = timer_q;
      req_d      = req_q;
      pop        = 1'b0;
      done       = 1'b0;
      tbl_set    = 1'b0;
      tbl_clr    = 1'b0;
      cmd_s      = CMD_NOP;
      cmd_bank_s = '0;
      cmd_addr_s = '0;
      case (state_q)
         ST_IDLE: begin
            if (!bus.fifo_empty) begin
               pop     = 1'b1;
               req_d   = bus.fifo_rdata;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (!lk_open)    state_d = ST_ACT;
            else if (lk_hit) state_d = ST_CAS;
            else             state_d = ST_PRE;
         end
         ST_PRE: begin
            cmd_s      = CMD_PRE;
            cmd_bank_s = req_bank;
            tbl_clr    = 1'b1;
            ret_d      = ST_PRE;
            if (T_RP == 1) state_d = ST_ACT;
            else begin
               timer_d = 4'(T_RP - 1);
               state_d = ST_WAIT;
            end
         end
         ST_ACT: begin
            cmd_s      = CMD_ACT;
            cmd_bank_s = req_bank;
            cmd_addr_s = req_row;
            tbl_set    = 1'b1;
            ret_d      = ST_ACT;
            if (T_RCD == 1) state_d = ST_CAS;
            else begin
               timer_d = 4'(T_RCD - 1);
               state_d = ST_WAIT;
            end
         end
         ST_CAS: begin
            cmd_s      = req_wr ? CMD_WR : CMD_RD;
            cmd_bank_s = req_bank;
            cmd_addr_s = ROW_BITS'(req_col);
            ret_d      = ST_CAS;
            timer_d    = req_wr ? 4'(T_WR - 1) : 4'(T_CL - 1);
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            // After CAS the completion cycle itself is spent in WAIT (terminal
            // count 0), so the next pop cannot coincide with req_done even for
            // a gap of 1. After PRE/ACT the next command state is the event
            // cycle, so WAIT ends one count earlier.
            if (ret_q == ST_CAS) begin
               if (timer_q == 4'd0) begin
                  done    = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  timer_d = timer_q - 4'd1;
               end
            end else if (timer_q <= 4'd1) begin
               state_d = (ret_q == ST_PRE) ? ST_ACT : ST_CAS;
            end else begin
               timer_d = timer_q - 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ret_q   <= ST_IDLE;
         timer_q <= '0;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         timer_q <= timer_d;
         req_q   <= req_d;
      end
   end

   assign bus.fifo_read_en = pop;
   assign bus.cmd          = cmd_s;
   assign bus.cmd_bank     = cmd_bank_s;
   assign bus.cmd_addr     = cmd_addr_s;
   assign bus.req_done     = done;
   assign bus.req_done_wr  = done & req_wr;
   assign bus.busy         = (state_q != ST_IDLE) | pop;
endmodule

// File: tb/tb_dram_req_issuer.sv
module tb_dram_req_issuer;
   localparam int BB = 2;
   localparam int RB = 8;
   localparam int CB = 4;
   localparam int RW = 15;
   localparam int NI = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   bit   started = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dram_req_issuer_if #(.BANK_BITS(BB), .ROW_BITS(RB), .COL_BITS(CB)) if0 ();
   dram_req_issuer_if #(.BANK_BITS(BB), .ROW_BITS(RB), .COL_BITS(CB)) if1 ();

   dram_req_issuer #(.BANK_BITS(BB), .ROW_BITS(RB), .COL_BITS(CB),
                     .T_RP(3), .T_RCD(3), .T_CL(4), .T_WR(4)) dut0 (
      .clk(clk), .reset(rst), .bus(if0.master));
   dram_req_issuer #(.BANK_BITS(BB), .ROW_BITS(RB), .COL_BITS(CB),
                     .T_RP(1), .T_RCD(1), .T_CL(1), .T_WR(1)) dut1 (
      .clk(clk), .reset(rst), .bus(if1.master));

   function automatic int trp(input int i);  return (i == 0) ? 3 : 1; endfunction
   function automatic int trcd(input int i); return (i == 0) ? 3 : 1; endfunction
   function automatic int tcl(input int i);  return (i == 0) ? 4 : 1; endfunction
   function automatic int twr(input int i);  return (i == 0) ? 4 : 1; endfunction

   // ---------------- bench-side FIFOs ----------------
   logic [RW-1:0] fmem [NI][128];
   int fhead [NI] = '{0, 0};
   int ftail [NI] = '{0, 0};

   assign if0.fifo_empty = (fhead[0] == ftail[0]);
   assign if0.fifo_rdata = fmem[0][fhead[0][6:0]];
   assign if1.fifo_empty = (fhead[1] == ftail[1]);
   assign if1.fifo_rdata = fmem[1][fhead[1][6:0]];

   always @(posedge clk) begin
      if (if0.fifo_read_en === 1'b1) fhead[0] <= fhead[0] + 1;
      if (if1.fifo_read_en === 1'b1) fhead[1] <= fhead[1] + 1;
   end

   logic       o_rd [NI], o_done [NI], o_wr [NI], o_busy [NI], f_empty [NI];
   logic [2:0] o_cmd [NI];
   logic [1:0] o_bank [NI];
   logic [7:0] o_addr [NI];
   assign o_rd[0] = if0.fifo_read_en;   assign o_rd[1] = if1.fifo_read_en;
   assign o_done[0] = if0.req_done;     assign o_done[1] = if1.req_done;
   assign o_wr[0] = if0.req_done_wr;    assign o_wr[1] = if1.req_done_wr;
   assign o_busy[0] = if0.busy;         assign o_busy[1] = if1.busy;
   assign o_cmd[0] = if0.cmd;           assign o_cmd[1] = if1.cmd;
   assign o_bank[0] = if0.cmd_bank;     assign o_bank[1] = if1.cmd_bank;
   assign o_addr[0] = if0.cmd_addr;     assign o_addr[1] = if1.cmd_addr;
   assign f_empty[0] = if0.fifo_empty;  assign f_empty[1] = if1.fifo_empty;

   function automatic logic [RW-1:0] mk(input int w, input int b, input int r, input int c);
      return {1'(w), 2'(b), 8'(r), 4'(c)};
   endfunction

   // ---------------- reference model: per-request schedule ----------------
   bit m_act  [NI];
   int m_pre  [NI], m_actc [NI], m_cas [NI], m_done [NI];
   int m_w    [NI], m_b [NI], m_r [NI], m_c [NI];
   bit m_open [NI][4];
   int m_orow [NI][4];
   int lp0 = -1;
   int lastp0 = 0;

   // Hand-computed expectations for the directed requests on instance 0,
   // relative to their pop cycle: k, off, cmd, bank, addr, done, wr, busy.
   typedef struct {
      int k; int off; int cmd; int bank; int addr; int done; int wr; int busy;
   } lit_t;
   lit_t lits [15] = '{
      '{0,  2, 1, 1, 'h12, 0, 0, 1}, '{0,  5, 2, 1, 3, 0, 0, 1},
      '{0,  9, 0, 0, 0,    1, 0, 1}, '{0, 10, 0, 0, 0, 0, 0, 0},
      '{1,  2, 2, 1, 5,    0, 0, 1}, '{1,  6, 0, 0, 0, 1, 0, 1},
      '{2,  2, 4, 1, 0,    0, 0, 1}, '{2,  5, 1, 1, 'h40, 0, 0, 1},
      '{2,  8, 3, 1, 7,    0, 0, 1}, '{2, 12, 0, 0, 0, 1, 1, 1},
      '{3,  2, 4, 1, 0,    0, 0, 1}, '{3,  5, 1, 1, 'h12, 0, 0, 1},
      '{4,  2, 1, 1, 'h12, 0, 0, 1}, '{4,  5, 2, 1, 3, 0, 0, 1},
      '{4,  9, 0, 0, 0,    1, 0, 1}
   };

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d cyc %0d got %0h want %0h", nm, i, cyc, act, exp);
      end
   endtask

   task automatic start_req(input int i, input int c, input logic [RW-1:0] h);
      int t;
      m_w[i] = int'(h[14]);
      m_b[i] = int'(h[13:12]);
      m_r[i] = int'(h[11:4]);
      m_c[i] = int'(h[3:0]);
      t = c + 2;
      m_pre[i] = -1;
      m_actc[i] = -1;
      if (m_open[i][m_b[i]] && m_orow[i][m_b[i]] == m_r[i]) begin
         m_cas[i] = t;
      end else if (m_open[i][m_b[i]]) begin
         m_pre[i]  = t;
         m_actc[i] = t + trp(i);
         m_cas[i]  = m_actc[i] + trcd(i);
      end else begin
         m_actc[i] = t;
         m_cas[i]  = t + trcd(i);
      end
      m_done[i] = m_cas[i] + ((m_w[i] != 0) ? twr(i) : tcl(i));
      m_open[i][m_b[i]] = 1'b1;
      m_orow[i][m_b[i]] = m_r[i];
      m_act[i] = 1'b1;
      if (i == 0) begin
         lp0++;
         lastp0 = c;
      end
   endtask

   task automatic check_inst(input int i);
      int c;
      int e_rd, e_busy, e_done, e_wr, e_cmd, e_bank, e_addr;
      c = cyc;
      e_rd = 0; e_busy = 0; e_done = 0; e_wr = 0; e_cmd = 0; e_bank = 0; e_addr = 0;
      if (rst) begin
         m_act[i] = 1'b0;
         for (int b = 0; b < 4; b++) m_open[i][b] = 1'b0;
         e_rd = (f_empty[i] === 1'b0) ? 1 : 0;
      end else begin
         if (m_act[i] && c > m_done[i]) m_act[i] = 1'b0;
         if (!m_act[i] && f_empty[i] === 1'b0) begin
            e_rd = 1;
            start_req(i, c, fmem[i][fhead[i][6:0]]);
         end
         if (m_act[i]) begin
            e_busy = 1;
            if (c == m_pre[i]) begin
               e_cmd = 4; e_bank = m_b[i];
            end else if (c == m_actc[i]) begin
               e_cmd = 1; e_bank = m_b[i]; e_addr = m_r[i];
            end else if (c == m_cas[i]) begin
               e_cmd = (m_w[i] != 0) ? 3 : 2; e_bank = m_b[i]; e_addr = m_c[i];
            end
            if (c == m_done[i]) begin
               e_done = 1;
               e_wr = m_w[i];
            end
         end
      end
      chk("read_en", i, 32'(o_rd[i]), e_rd);
      chk("busy", i, 32'(o_busy[i]), e_busy);
      chk("cmd", i, 32'(o_cmd[i]), e_cmd);
      chk("cmd_bank", i, 32'(o_bank[i]), e_bank);
      chk("cmd_addr", i, 32'(o_addr[i]), e_addr);
      chk("req_done", i, 32'(o_done[i]), e_done);
      chk("req_done_wr", i, 32'(o_wr[i]), e_wr);
      if (i == 0 && !rst) begin
         for (int n = 0; n < 15; n++) begin
            if (lits[n].k == lp0 && c - lastp0 == lits[n].off) begin
               chk("lit_cmd", i, 32'(o_cmd[0]), lits[n].cmd);
               chk("lit_bank", i, 32'(o_bank[0]), lits[n].bank);
               chk("lit_addr", i, 32'(o_addr[0]), lits[n].addr);
               chk("lit_done", i, 32'(o_done[0]), lits[n].done);
               chk("lit_wr", i, 32'(o_wr[0]), lits[n].wr);
               chk("lit_busy", i, 32'(o_busy[0]), lits[n].busy);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < NI; i++) check_inst(i);
      end
   end

   // ---------------- stimulus ----------------
   task automatic push(input int i, input logic [RW-1:0] r);
      fmem[i][ftail[i][6:0]] = r;
      ftail[i] = ftail[i] + 1;
   endtask

   task automatic wait_idle(input int i);
      int n;
      n = 0;
      while (!(fhead[i] == ftail[i] && o_busy[i] === 1'b0)) begin
         @(posedge clk); #1;
         n++;
         if (n > 3000) begin
            $display("FAIL wait_idle inst%0d timeout after %0d cycles", i, n);
            $fatal(1, "bench stopped");
         end
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic wait_pop(input int i);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n > 200) begin
            $display("FAIL wait_pop inst%0d timeout", i);
            $fatal(1, "bench stopped");
         end
      end while (o_rd[i] !== 1'b1);
   endtask

   int rows [4] = '{'h12, 'h40, 'h7f, 'h00};

   initial begin
      // reset asserted mid-cycle with an empty FIFO
      #7;
      rst = 1'b1;
      started = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;

      // closed bank, hit, conflict on instance 0
      push(0, mk(0, 1, 'h12, 3)); wait_idle(0);
      push(0, mk(0, 1, 'h12, 5)); wait_idle(0);
      push(0, mk(1, 1, 'h40, 7)); wait_idle(0);

      // reset during the ACT->CAS wait, then the row must be re-activated
      push(0, mk(0, 1, 'h12, 3));
      wait_pop(0);
      repeat (6) @(posedge clk);
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      push(0, mk(0, 1, 'h12, 3)); wait_idle(0);

      // back-to-back requests with all gaps 1
      push(1, mk(0, 2, 'h33, 1));
      push(1, mk(1, 2, 'h33, 2));
      push(1, mk(0, 2, 'h44, 9));
      wait_idle(1);

      // randomized traffic into both instances
      for (int n = 0; n < 60; n++) begin
         logic [RW-1:0] r;
         r = mk(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                rows[$urandom_range(0, 3)], int'($urandom_range(0, 15)));
         if (ftail[0] - fhead[0] < 100 && ftail[1] - fhead[1] < 100) begin
            push(0, r);
            push(1, r);
         end
         repeat ($urandom_range(0, 12)) @(posedge clk);
         #1;
      end
      wait_idle(0);
      wait_idle(1);
      repeat (5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "bench stopped");
   end
endmodule
